// File: rtl/quant_pkg.sv
// Shared types and constant helpers for the quantized max-pool stage.
// MAXPOOL_PAD_ADDR_EN selects the zero-padded next-layer frame for address sizing.
package quant_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LAST = 2'd2,
    ST_DONE = 2'd3
  } mp_state_e;

  // Never returns less than 1 so every derived vector has a legal width.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((32'sd1 << r) < n) r = r + 1;
    return r;
  endfunction

  function automatic int out_dim(input int n);
    return n / 2;
  endfunction

  function automatic int addr_width(input int ch, input int h, input int w);
`ifdef MAXPOOL_PAD_ADDR_EN
    return clog2(ch * (out_dim(h) + 2) * (out_dim(w) + 2));
`else
    return clog2(ch * out_dim(h) * out_dim(w));
`endif
  endfunction

  function automatic logic [7:0] max_u8(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/maxpool_line_buffer.sv
// One-row buffer of horizontal maxima: one write port, one registered read port.
module maxpool_line_buffer #(
  parameter int DEPTH = 14,
  parameter int AW    = 4
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]    wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]    rdata_o
);

  logic [7:0] mem_q [DEPTH];
  logic [7:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/quantized_maxpool2d.sv
// 2x2 stride-2 uint8 max-pool over a channel-major raster stream, emitting write addresses.
// MAXPOOL_PAD_ADDR_EN: addresses target the interior of a zero-padded next-layer frame.
module quantized_maxpool2d
  import quant_pkg::*;
#(
  parameter  int CHANNELS  = 128,
  parameter  int IN_WIDTH  = 28,
  parameter  int IN_HEIGHT = 28,
  localparam int AW        = addr_width(CHANNELS, IN_HEIGHT, IN_WIDTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [7:0]    in_data_i,
  input  logic          in_valid_i,
  output logic [7:0]    out_data_o,
  output logic          out_valid_o,
  output logic [AW-1:0] out_addr_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_idle_o
);

  localparam int OUT_W = out_dim(IN_WIDTH);
  localparam int OUT_H = out_dim(IN_HEIGHT);
  localparam int CW    = clog2(IN_WIDTH);
  localparam int RW    = clog2(IN_HEIGHT);
  localparam int HW    = clog2(CHANNELS);
  localparam int LW    = clog2(OUT_W);

`ifdef MAXPOOL_PAD_ADDR_EN
  // Skip the right border plus the next row's left border; at channel end also skip the bottom
  // border row, the next channel's top border row and its left border cell.
  localparam logic [AW-1:0] ADDR_INIT = AW'(OUT_W + 3);
  localparam logic [AW-1:0] STEP_ROW  = AW'(3);
  localparam logic [AW-1:0] STEP_CH   = AW'(2 * OUT_W + 7);
`else
  localparam logic [AW-1:0] ADDR_INIT = '0;
`endif

  mp_state_e     state_q;
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic [HW-1:0] ch_q;
  logic [7:0]    h_q;
  logic [AW-1:0] wa_q;
  logic [7:0]    out_data_q;
  logic          out_valid_q;
  logic [AW-1:0] out_addr_q;
  logic          busy_q;
  logic          done_q;
  logic          err_idle_q;

  logic          accept, col_last, row_last, ch_last, pool_px;
  logic          lb_we, lb_re, emit;
  logic [7:0]    hmax, lb_rdata;
  logic [LW-1:0] lb_addr;
  logic [AW-1:0] addr_step;

  always_comb begin
    accept    = (state_q == ST_RUN) && in_valid_i;
    col_last  = (int'(col_q) == IN_WIDTH - 1);
    row_last  = (int'(row_q) == IN_HEIGHT - 1);
    ch_last   = (int'(ch_q) == CHANNELS - 1);
    // Trailing odd column/row is counted but never pooled.
    pool_px   = (int'(col_q) < 2 * OUT_W) && (int'(row_q) < 2 * OUT_H);
    lb_addr   = LW'(col_q >> 1);
    hmax      = max_u8(h_q, in_data_i);
    lb_we     = accept && pool_px && col_q[0] && !row_q[0];
    lb_re     = accept && pool_px && !col_q[0] && row_q[0];
    emit      = accept && pool_px && col_q[0] && row_q[0];
`ifdef MAXPOOL_PAD_ADDR_EN
    addr_step = AW'(1);
    if (int'(col_q) == 2 * OUT_W - 1) begin
      addr_step = (int'(row_q) == 2 * OUT_H - 1) ? STEP_CH : STEP_ROW;
    end
`else
    addr_step = AW'(1);
`endif
  end

  maxpool_line_buffer #(
    .DEPTH (OUT_W),
    .AW    (LW)
  ) u_line_buffer (
    .clk_i   (clk_i),
    .we_i    (lb_we),
    .waddr_i (lb_addr),
    .wdata_i (hmax),
    .re_i    (lb_re),
    .raddr_i (lb_addr),
    .rdata_o (lb_rdata)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      ch_q        <= '0;
      h_q         <= '0;
      wa_q        <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_idle_q  <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            state_q    <= ST_RUN;
            col_q      <= '0;
            row_q      <= '0;
            ch_q       <= '0;
            wa_q       <= ADDR_INIT;
            busy_q     <= 1'b1;
            err_idle_q <= 1'b0;
          end else if (in_valid_i) begin
            err_idle_q <= 1'b1;
          end
        end
        ST_RUN: begin
          if (accept) begin
            if (!col_q[0]) h_q <= in_data_i;
            if (emit) begin
              out_data_q  <= max_u8(lb_rdata, hmax);
              out_valid_q <= 1'b1;
              out_addr_q  <= wa_q;
              wa_q        <= wa_q + addr_step;
            end
            if (col_last) begin
              col_q <= '0;
              if (row_last) begin
                row_q <= '0;
                ch_q  <= ch_q + HW'(1);
              end else begin
                row_q <= row_q + RW'(1);
              end
            end else begin
              col_q <= col_q + CW'(1);
            end
            if (col_last && row_last && ch_last) begin
              state_q <= ST_LAST;
              busy_q  <= 1'b0;
            end
          end
        end
        ST_LAST: begin
          state_q <= ST_DONE;
          done_q  <= 1'b1;
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
          if (in_valid_i) err_idle_q <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;
  assign out_addr_o  = out_addr_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_idle_o  = err_idle_q;

endmodule

// File: tb/tb_quantized_maxpool2d.sv
// Directed bench for quantized_maxpool2d on a 2-channel 5x5 frame (odd dimensions).
// Expected addresses follow MAXPOOL_PAD_ADDR_EN when the bench is built with it.
module tb_quantized_maxpool2d;

  localparam int CH   = 2;
  localparam int W    = 5;
  localparam int H    = 5;
  localparam int NPIX = CH * W * H;
  localparam int NOUT = CH * 4;
`ifdef MAXPOOL_PAD_ADDR_EN
  localparam int AW = 5;
`else
  localparam int AW = 3;
`endif

  logic          clk, rst, start, in_valid;
  logic [7:0]    in_data;
  logic [7:0]    out_data;
  logic          out_valid;
  logic [AW-1:0] out_addr;
  logic          busy, done, err_idle;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  logic [7:0]    pix [NPIX];
  logic [7:0]    got_data [$];
  logic [AW-1:0] got_addr [$];
  logic [7:0]    exp_a [NOUT];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  quantized_maxpool2d #(
    .CHANNELS  (CH),
    .IN_WIDTH  (W),
    .IN_HEIGHT (H)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .in_data_i   (in_data),
    .in_valid_i  (in_valid),
    .out_data_o  (out_data),
    .out_valid_o (out_valid),
    .out_addr_o  (out_addr),
    .busy_o      (busy),
    .done_o      (done),
    .err_idle_o  (err_idle)
  );

  always @(negedge clk) begin
    if (out_valid) begin
      got_data.push_back(out_data);
      got_addr.push_back(out_addr);
    end
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_data(input int k);
    int ch, r, c, b;
    logic [7:0] m;
    ch = k / 4;
    r  = (k % 4) / 2;
    c  = k % 2;
    b  = ch * W * H + (2 * r) * W + 2 * c;
    m  = pix[b];
    if (pix[b + 1] > m) m = pix[b + 1];
    if (pix[b + W] > m) m = pix[b + W];
    if (pix[b + W + 1] > m) m = pix[b + W + 1];
    return m;
  endfunction

  function automatic logic [31:0] model_addr(input int k);
    int ch, r, c;
    ch = k / 4;
    r  = (k % 4) / 2;
    c  = k % 2;
`ifdef MAXPOOL_PAD_ADDR_EN
    return 32'(ch * 16 + (r + 1) * 4 + (c + 1));
`else
    return 32'(ch * 4 + r * 2 + c);
`endif
  endfunction

  task automatic clear_capture();
    got_data.delete();
    got_addr.delete();
    done_cnt = 0;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic feed(input int npix, input bit gaps);
    for (int i = 0; i < npix; i++) begin
      in_data  = pix[i];
      in_valid = 1'b1;
      @(negedge clk);
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20 && done_cnt == 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_frame(input string pfx, input bit use_model);
    check($sformatf("%s_nout", pfx), 32'(got_data.size()), 32'(NOUT));
    for (int k = 0; k < NOUT; k++) begin
      if (k < got_data.size()) begin
        check($sformatf("%s_data%0d", pfx, k), 32'(got_data[k]),
              use_model ? 32'(model_data(k)) : 32'(exp_a[k]));
        check($sformatf("%s_addr%0d", pfx, k), 32'(got_addr[k]), model_addr(k));
      end
    end
    check($sformatf("%s_done_cnt", pfx), 32'(done_cnt), 32'd1);
    check($sformatf("%s_busy_after", pfx), 32'(busy), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_addr", 32'(out_addr), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err_idle", 32'(err_idle), 32'd0);
    rst = 1'b0;

    // ch0: 10*row+col; ch1: all 0xFF except pixel (1,1) = 0
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        pix[r * W + c]         = 8'(10 * r + c);
        pix[W * H + r * W + c] = (r == 1 && c == 1) ? 8'h00 : 8'hFF;
      end
    exp_a = '{8'd11, 8'd13, 8'd31, 8'd33, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

    clear_capture();
    pulse_start();
    check("run_busy", 32'(busy), 32'd1);
    feed(NPIX, 1'b0);
    wait_done();
    check_frame("cont", 1'b0);

    clear_capture();
    pulse_start();
    feed(NPIX, 1'b1);
    wait_done();
    check_frame("gaps", 1'b0);

    clear_capture();
    @(negedge clk) in_valid = 1'b1;
    @(negedge clk) in_valid = 1'b0;
    @(negedge clk);
    check("idle_err_set", 32'(err_idle), 32'd1);
    check("idle_no_output", 32'(got_data.size()), 32'd0);
    pulse_start();
    check("start_clears_err", 32'(err_idle), 32'd0);

    // finish the armed frame with random data
    for (int i = 0; i < NPIX; i++) pix[i] = 8'($urandom_range(0, 255));
    feed(NPIX, 1'b0);
    wait_done();
    check_frame("rand1", 1'b1);

    // abort mid-frame right after the pixel that emits output (ch0,1,1)
    clear_capture();
    pulse_start();
    feed(19, 1'b0);
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_out_data", 32'(out_data), 32'd0);
    check("abort_out_addr", 32'(out_addr), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_no_done", 32'(done_cnt), 32'd0);

    clear_capture();
    for (int i = 0; i < NPIX; i++) pix[i] = 8'($urandom_range(0, 255));
    pulse_start();
    feed(NPIX, 1'b1);
    wait_done();
    check_frame("rand2", 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
